// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu command sequencer.
// State encoding, flag bit positions and default sizes.
package alu_seq_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_P = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers.
// Read data is the head entry; pop advances on the edge.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = 2 * W_DEF + 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit alu: queues commands, drives
// registered operands, captures results and keeps an accumulator.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [3:0]   cmd_sl,
  input  logic         cmd_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_c,
  input  logic         alu_z,
  input  logic         alu_s,
  input  logic         alu_p,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_flags,
  output logic [W-1:0] acc,
  output logic         busy
);

  localparam int DW = 2 * W + 5;

  state_t        r_state;
  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  logic [3:0]    r_alu_sl;
  logic [W-1:0]  r_res_data;
  logic [3:0]    r_res_flags;
  logic [W-1:0]  r_acc;
  logic          r_res_valid;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_din;
  logic [DW-1:0] w_dout;
  logic [W-1:0]  w_f_a;
  logic [W-1:0]  w_f_b;
  logic [3:0]    w_f_sl;
  logic          w_f_acc;

  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_din     = {cmd_acc, cmd_sl, cmd_b, cmd_a};
  assign w_f_a     = w_dout[W-1:0];
  assign w_f_b     = w_dout[2*W-1:W];
  assign w_f_sl    = w_dout[2*W+3:2*W];
  assign w_f_acc   = w_dout[2*W+4];

  // Pop only from IDLE, or from RESP when the held result drains.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) ||
                  ((r_state == S_RESP) && res_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sl    <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a  <= w_f_acc ? r_acc : w_f_a;
        r_alu_b  <= w_f_b;
        r_alu_sl <= w_f_sl;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res_data          <= alu_out;
          r_res_flags[FLG_C]  <= alu_c;
          r_res_flags[FLG_Z]  <= alu_z;
          r_res_flags[FLG_S]  <= alu_s;
          r_res_flags[FLG_P]  <= alu_p;
          r_acc               <= alu_out;
          r_res_valid         <= 1'b1;
          r_state             <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_pop ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sl    = r_alu_sl;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;
  assign acc       = r_acc;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with an adder alu stub.
// Stimulus pushes expected results; a negedge monitor pops them.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sl;
  logic       cmd_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sl;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_z;
  logic       alu_s;
  logic       alu_p;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic [7:0] acc;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  m_acc;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sl    (cmd_sl),
    .cmd_acc   (cmd_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sl    (alu_sl),
    .alu_out   (alu_out),
    .alu_c     (alu_c),
    .alu_z     (alu_z),
    .alu_s     (alu_s),
    .alu_p     (alu_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .acc       (acc),
    .busy      (busy)
  );

  // alu stub: Out=A+B, flags from the sum
  always_comb begin
    {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    alu_z = (alu_out == 8'h00);
    alu_s = alu_out[7];
    alu_p = ^alu_out;
  end

  function automatic logic [11:0] model(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[8], s[7:0] == 8'h00, s[7], ^s[7:0], s[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry/exit at posedge+#1; holds cmd_valid until accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sl, input logic ab);
    logic [11:0] e;
    bit done;
    done = 0;
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_sl = sl; cmd_acc = ab;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        e = model(ab ? m_acc : a, b);
        m_acc = e[7:0];
        exp_q.push_back(e);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc(1);
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    chk("drain_done", done, 1);
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", res_data, 9'h100);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e[7:0]);
        chk("res_flags", res_flags, e[11:8]);
      end
    end
  end

  initial begin
    int seen[$];
    logic [7:0] held;
    rst = 1'b1; cmd_valid = 0; cmd_a = 0; cmd_b = 0;
    cmd_sl = 0; cmd_acc = 0; res_ready = 0; m_acc = 0;

    // reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sl", alu_sl, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(1);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // single op with latency check
    push(8'hf8, 8'h67, 4'h0, 1'b0);
    cyc(1);
    chk("single_alu_a", alu_a, 8'hf8);
    chk("single_alu_b", alu_b, 8'h67);
    cyc(1);
    chk("single_res_valid", res_valid, 1);
    chk("single_res_data", res_data, 8'h5f);
    chk("single_res_flags", res_flags, 4'b1000);
    chk("single_acc", acc, 8'h5f);
    res_ready = 1'b1;
    drain();

    // chain on accumulator
    push(8'h01, 8'h02, 4'h1, 1'b0);
    push(8'h55, 8'h03, 4'h5, 1'b1);
    cyc(2);
    chk("chain_alu_a", alu_a, 8'h03);
    chk("chain_alu_b", alu_b, 8'h03);
    chk("chain_alu_sl", alu_sl, 4'h5);
    drain();
    chk("chain_acc", acc, 8'h06);

    // backpressure: 1 held + 4 queued, 6th refused
    res_ready = 1'b0;
    push(8'h10, 8'h20, 4'h2, 1'b0);
    push(8'h80, 8'h80, 4'h3, 1'b0);
    push(8'h00, 8'hff, 4'h4, 1'b1);
    push(8'h7f, 8'h01, 4'h6, 1'b0);
    push(8'hc3, 8'h3c, 4'h7, 1'b0);
    cmd_valid = 1'b1;
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_sl = 4'h8; cmd_acc = 1'b0;
    @(negedge clk);
    chk("bp_cmd_ready", cmd_ready, 0);
    held = res_data;
    chk("bp_head_data", res_data, 8'h30);
    @(posedge clk); #1;
    cyc(3);
    chk("bp_res_stable", res_data, held);
    chk("bp_res_valid", res_valid, 1);
    res_ready = 1'b1;
    push(8'h11, 8'h22, 4'h8, 1'b0);
    drain();

    // streaming: one result every 2 cycles
    res_ready = 1'b0;
    push(8'h01, 8'h01, 4'h0, 1'b0);
    push(8'h02, 8'h02, 4'h0, 1'b0);
    push(8'h03, 8'h03, 4'h0, 1'b0);
    push(8'h04, 8'h9a, 4'h9, 1'b0);
    cyc(2);
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) seen.push_back(i);
    end
    @(posedge clk); #1;
    chk("stream_count", seen.size(), 4);
    for (int i = 1; i < seen.size(); i++)
      chk("stream_spacing", seen[i] - seen[i-1], 2);
    chk("stream_busy", busy, 0);
    chk("idle_hold_alu_b", alu_b, 8'h9a);
    chk("idle_hold_alu_sl", alu_sl, 4'h9);

    // reset mid-op: RESP with 2 queued
    res_ready = 1'b0;
    push(8'h05, 8'h06, 4'h1, 1'b0);
    push(8'h07, 8'h08, 4'h1, 1'b0);
    push(8'h09, 8'h0a, 4'h1, 1'b0);
    cyc(1);
    chk("mid_res_valid_pre", res_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_res_valid_async", res_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    chk("mid_acc", acc, 0);
    exp_q.delete();
    m_acc = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    cyc(10);
    chk("mid_no_stale", res_valid, 0);
    chk("mid_idle", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
